usb_tx_ctrl: RTL and testbench

- Transmit-side sequencer for the USB serial link.
- Takes packet bytes over a valid/ready stream and frames them as SYNC, then payload, then EOP.
- Serializes each byte LSB-first at one bit per clk, bit-stuffs, and NRZI-encodes onto differential dp/dm.
- Owns the bus output enable and returns the line to idle J after each packet.

---
 rtl/usb_tx_ctrl.sv | 83 ++++++++
 tb/tb_usb_tx_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/usb_tx_ctrl.sv
// usb_tx_ctrl: frames stream bytes as SYNC/payload/EOP with bit stuffing and NRZI onto dp/dm
module usb_tx_ctrl #(
  parameter int STUFF_LEN  = 6,
  parameter int SE0_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic       in_ready,
  output logic       dp,
  output logic       dm,
  output logic       bus_oe,
  output logic       busy,
  output logic       done,
  output logic       underrun
);
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] SYNC    = 3'd1;
  localparam logic [2:0] DATA    = 3'd2;
  localparam logic [2:0] STUFF   = 3'd3;
  localparam logic [2:0] EOP_SE0 = 3'd4;
  localparam logic [2:0] EOP_J   = 3'd5;
  localparam int OW = $clog2(STUFF_LEN + 1);
  localparam int EW = $clog2(SE0_CYCLES + 1);
  logic [2:0] state, nstate, cnt;
  logic [7:0] sreg;
  logic [OW-1:0] ones;
  logic [EW-1:0] ecnt;
  logic last_r, line, eop_after, raw, tx_line, load_cycle, stuff_now, sending;
  always_comb begin
    sending    = state == SYNC || state == DATA || state == STUFF;
    raw        = state == DATA ? sreg[0] : state == SYNC ? cnt == 3'd7 : 1'b0;
    tx_line    = raw ? line : ~line;
    load_cycle = (state == SYNC || (state == DATA && !last_r)) && cnt == 3'd7;
    in_ready   = load_cycle;
    underrun   = load_cycle && !in_valid;
    stuff_now  = state == DATA && raw && ones == OW'(STUFF_LEN - 1);
    busy       = state != IDLE;
    bus_oe     = busy;
    dp         = state == EOP_SE0 ? 1'b0 : sending ? tx_line : 1'b1;
    dm         = sending ? ~tx_line : 1'b0;
    nstate     = IDLE;
    case (state)
      IDLE:    nstate = in_valid ? SYNC : IDLE;
      SYNC:    nstate = cnt != 3'd7 ? SYNC : in_valid ? DATA : EOP_SE0;
      DATA:    nstate = underrun ? EOP_SE0 : stuff_now ? STUFF :
                        (cnt == 3'd7 && last_r) ? EOP_SE0 : DATA;
      STUFF:   nstate = eop_after ? EOP_SE0 : DATA;
      EOP_SE0: nstate = ecnt == EW'(SE0_CYCLES - 1) ? EOP_J : EOP_SE0;
      default: nstate = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      ecnt      <= '0;
      ones      <= '0;
      sreg      <= '0;
      last_r    <= 1'b0;
      line      <= 1'b1;
      eop_after <= 1'b0;
      done      <= 1'b0;
    end else begin
      state <= nstate;
      cnt   <= (state == SYNC || state == DATA) ? cnt + 3'd1 : state == IDLE ? 3'd0 : cnt;
      ecnt  <= state == EOP_SE0 ? ecnt + 1'b1 : '0;
      ones  <= (state == SYNC || state == DATA) && raw ? ones + 1'b1 : '0;
      line  <= sending ? tx_line : 1'b1;
      done  <= state == EOP_J;
      // the byte index wraps to 0 on bit 7, so a pending stuff must remember whether EOP follows
      if (stuff_now) eop_after <= cnt == 3'd7 && last_r;
      if (load_cycle && in_valid) begin
        sreg   <= in_data;
        last_r <= in_last;
      end else if (state == DATA) begin
        sreg <= sreg >> 1;
      end
    end
  end
endmodule

// File: tb/tb_usb_tx_ctrl.sv
// tb_usb_tx_ctrl: scoreboard bench; expected line symbols are queued per bus_oe cycle and popped by a monitor
module tb_usb_tx_ctrl;
  logic clk, rst, in_valid, in_last, in_ready, dp, dm, bus_oe, busy, done, underrun;
  logic [7:0] in_data;
  typedef struct {byte sym; byte flg; bit last; int gap;} exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;
  bit prev_end = 0;
  int idle_cnt = 0;

  usb_tx_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .dp(dp), .dm(dm), .bus_oe(bus_oe), .busy(busy), .done(done),
    .underrun(underrun)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic byte sym_of(logic p, logic m);
    return (p && !m) ? "J" : (!p && m) ? "K" : (!p && !m) ? "0" : "?";
  endfunction

  function automatic byte flg_of(logic r, logic u);
    return (r && u) ? "x" : r ? "r" : u ? "u" : ".";
  endfunction

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // line chars: J, K, 0 = SE0; r1/r2 mark in_ready cycles, u marks the underrun cycle
  task automatic push(input string s, input int r1, input int r2, input int u, input int gap);
    for (int i = 0; i < s.len(); i++) begin
      exp_t e;
      e.sym  = s[i];
      e.flg  = (i == r1 || i == r2) ? ((i == u) ? "x" : "r") : ".";
      e.last = (i == s.len() - 1);
      e.gap  = (i == 0) ? gap : -1;
      q.push_back(e);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 100);
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: in_ready never rose within %0d cycles", n);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int n, input logic [7:0] b0, input logic [7:0] b1, input bit tail_last);
    for (int k = 0; k < n; k++) begin
      in_data  = (k == 0) ? b0 : b1;
      in_last  = (k == n - 1) && tail_last;
      in_valid = 1;
      wait_ready();
    end
    in_valid = 0;
    in_last  = 0;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((q.size() != 0 || busy || prev_end) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: %0d symbols still queued, busy=%b", q.size(), busy);
    end
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    exp_t e;
    byte gs, gf;
    if (rst) begin
      prev_end = 0;
      idle_cnt = 0;
    end else begin
      if (done || prev_end) begin
        checks++;
        if (done !== prev_end) begin
          errors++;
          $display("FAIL done_pulse: got %b want %b", done, prev_end);
        end
      end
      prev_end = 0;
      if (bus_oe) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_tx: got line %s with nothing expected", sym_of(dp, dm));
        end else begin
          e  = q.pop_front();
          gs = sym_of(dp, dm);
          gf = flg_of(in_ready, underrun);
          checks++;
          if (gs != e.sym || gf != e.flg) begin
            errors++;
            $display("FAIL symbol: got %s/%s want %s/%s (%0d left)", gs, gf, e.sym, e.flg, q.size());
          end
          if (e.gap >= 0) begin
            checks++;
            if (idle_cnt != e.gap) begin
              errors++;
              $display("FAIL idle_gap: got %0d want %0d", idle_cnt, e.gap);
            end
          end
          prev_end = e.last;
          if (e.last) idle_cnt = 0;
        end
      end else begin
        idle_cnt++;
        if (in_ready || underrun) begin
          checks++;
          errors++;
          $display("FAIL idle_strobe: got ready=%b underrun=%b want 0/0", in_ready, underrun);
        end
      end
    end
  end

  initial begin
    rst = 1; in_valid = 0; in_data = 0; in_last = 0;
    #1;
    chk("rst_bus_oe", bus_oe, 0);
    chk("rst_dp", dp, 1);
    chk("rst_dm", dm, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", in_ready, 0);
    chk("rst_underrun", underrun, 0);
    @(posedge clk); @(posedge clk);
    #2 rst = 0;
    push("KJKJKJKKJKJKJKJK00J", 7, -1, -1, -1);
    send(1, 8'h00, 8'h00, 1);
    wait_done();
    push("KJKJKJKKKKKKKJJJJ00J", 7, -1, -1, -1);
    send(1, 8'hFF, 8'h00, 1);
    wait_done();
    push("KJKJKJKKKKKKKJJKJKJKJKJKK00J", 7, 16, -1, -1);
    send(2, 8'h3F, 8'h80, 1);
    wait_done();
    push("KJKJKJKKKJJKKJJK00J", 7, 15, 15, -1);
    send(1, 8'h55, 8'h00, 0);
    wait_done();
    push("KJKJKJKKJKJKJKJK00J", 7, -1, -1, -1);
    send(1, 8'h00, 8'h00, 1);
    repeat (3) @(posedge clk);
    #2 rst = 1;
    #1;
    chk("arst_bus_oe", bus_oe, 0);
    chk("arst_dp", dp, 1);
    chk("arst_dm", dm, 0);
    chk("arst_busy", busy, 0);
    q.delete();
    repeat (2) begin
      @(negedge clk);
      chk("arst_done", done, 0);
    end
    @(posedge clk);
    #2 rst = 0;
    @(negedge clk);
    chk("post_rst_done", done, 0);
    chk("post_rst_busy", busy, 0);
    push("KJKJKJKKJKJKJKJK00J", 7, -1, -1, -1);
    send(1, 8'h00, 8'h00, 1);
    wait_done();
    push("KJKJKJKKJKJKJKJK00J", 7, -1, -1, -1);
    push("KJKJKJKKKKKKKJJJJ00J", 7, -1, -1, 1);
    send(1, 8'h00, 8'h00, 1);
    send(1, 8'hFF, 8'h00, 1);
    wait_done();
    chk("queue_drained", 8'(q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
